qedmma_fp_divider: RTL and testbench

QEDMMA_FP_DIVIDER -- requirements
Module: qedmma_fp_divider

---
 rtl/qedmma_fp_divider.sv | 153 +++++++++++++++
 tb/tb_qedmma_fp_divider.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/qedmma_fp_divider.sv
// Signed Q15.16 sequential divider: restoring radix-2 division, 48 quotient bits, saturating output.
// Latency 50 cycles from accept to out_valid; 1 cycle for a zero divisor. Optional QEDMMA_DIV_ROUND_EN rounds to nearest.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module qedmma_fp_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_by_zero,
    output logic                  overflow
);
    localparam int MAG_W = DATA_WIDTH + 1;
    localparam int NUM_W = DATA_WIDTH + FRAC_BITS;
    localparam logic [5:0] LAST_CNT = 6'(NUM_W - 1);
    localparam logic [NUM_W:0] POS_LIM = {{(FRAC_BITS+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [NUM_W:0] NEG_LIM = {{(FRAC_BITS+1){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic [MAG_W-1:0]      dmag_q, dmag_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;

    logic [MAG_W-1:0]      a_mag, b_mag, trial;
    logic                  trial_ge;
    logic [NUM_W:0]        mag;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        dmag_d      = dmag_q;
        num_d       = num_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        // Magnitudes are one bit wider so |-2^31| is exact.
        a_mag    = dividend[DATA_WIDTH-1] ? -{dividend[DATA_WIDTH-1], dividend} : {1'b0, dividend};
        b_mag    = divisor[DATA_WIDTH-1]  ? -{divisor[DATA_WIDTH-1], divisor}   : {1'b0, divisor};
        trial    = {rem_q, num_q[NUM_W-1]};
        trial_ge = (trial >= dmag_q);
        mag      = {1'b0, num_q};
`ifdef QEDMMA_DIV_ROUND_EN
        if ({rem_q, 1'b0} >= dmag_q) begin
            mag = mag + 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        quotient_d = DATA_WIDTH'(1) << FRAC_BITS;
                        dbz_d      = 1'b1;
                        state_d    = DONE;
                    end else begin
                        sign_d  = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                        dmag_d  = b_mag;
                        num_d   = {a_mag[DATA_WIDTH-1:0], {FRAC_BITS{1'b0}}};
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // The numerator shifts out the top while quotient bits shift in below.
                rem_d = trial_ge ? DATA_WIDTH'(trial - dmag_q) : trial[DATA_WIDTH-1:0];
                num_d = {num_q[NUM_W-2:0], trial_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (mag > (sign_q ? NEG_LIM : POS_LIM)) begin
                    ovf_d      = 1'b1;
                    quotient_d = sign_q ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end else begin
                    quotient_d = sign_q ? -mag[DATA_WIDTH-1:0] : mag[DATA_WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                // First DONE cycle raises out_valid; the handshake only counts once it is visible.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            dmag_q      <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            dmag_q      <= dmag_d;
            num_q       <= num_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_qedmma_fp_divider.sv
// Directed-vector bench for qedmma_fp_divider; expectations follow QEDMMA_DIV_ROUND_EN when defined.
module tb_qedmma_fp_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

`ifdef QEDMMA_DIV_ROUND_EN
    localparam logic [31:0] EXP_2_3  = 32'h0000_AAAB;
    localparam logic [31:0] EXP_M2_3 = 32'hFFFF_5555;
`else
    localparam logic [31:0] EXP_2_3  = 32'h0000_AAAA;
    localparam logic [31:0] EXP_M2_3 = 32'hFFFF_5556;
`endif

    qedmma_fp_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = 32'h0000_0001;
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_dz, input logic exp_ov,
                          input int exp_lat, input int stall);
        int  lat;
        bit  stable;
        accept(a, b);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_quotient"}, {32'd0, quotient}, {32'd0, exp_q});
        chk({tag, "_flags"}, {62'd0, div_by_zero, overflow}, {62'd0, exp_dz, exp_ov});
        chk({tag, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (out_valid !== 1'b1 || quotient !== exp_q || div_by_zero !== exp_dz ||
                    overflow !== exp_ov || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_stall_stable"}, {63'd0, stable}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {29'd0, in_ready, out_valid, quotient, div_by_zero, overflow}, 64'd0);
        rst = 1'b0;
        tick();
        chk("reset_release_in_ready", {63'd0, in_ready}, 64'd1);

        do_div("3_div_2",   32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 50, 0);
        do_div("2_div_3",   32'h0002_0000, 32'h0003_0000, EXP_2_3,       1'b0, 1'b0, 50, 0);
        do_div("m2_div_3",  32'hFFFE_0000, 32'h0003_0000, EXP_M2_3,      1'b0, 1'b0, 50, 0);
        do_div("div_zero",  32'h1234_0000, 32'h0000_0000, 32'h0001_0000, 1'b1, 1'b0, 1,  0);
        do_div("pos_sat",   32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 50, 0);
        do_div("min_exact", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 50, 0);
        do_div("min_neg1",  32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 50, 0);
        do_div("neg_sat",   32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b1, 50, 0);
        do_div("m1p5",      32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 50, 10);

        // Abort an operation partway through CALC.
        accept(32'h0005_0000, 32'h0002_0000);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        tick();
        chk("abort_in_ready_after", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        chk("abort_no_out_valid", {63'd0, seen}, 64'd0);
        do_div("after_abort", 32'h0005_0000, 32'h0002_0000, 32'h0002_8000, 1'b0, 1'b0, 50, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
